// File: rtl/sha256_padder_if.sv
// Message-word and chunk handshake bundle between a producer and the SHA-256 padder.
// slave is the padder side; master is the message source / chunk sink side.
interface sha256_padder_if;
  logic              msg_vld;
  logic              msg_rdy;
  logic [31:0]       msg_data;
  logic              msg_last;
  logic [2:0]        msg_bytes;
  logic              chunk_vld;
  logic              chunk_rdy;
  logic [15:0][31:0] chunk_data;
  logic              chunk_last;

  modport slave (
    input  msg_vld, msg_data, msg_last, msg_bytes, chunk_rdy,
    output msg_rdy, chunk_vld, chunk_data, chunk_last
  );

  modport master (
    output msg_vld, msg_data, msg_last, msg_bytes, chunk_rdy,
    input  msg_rdy, chunk_vld, chunk_data, chunk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian words into 512-bit chunks, appends the 0x80
// marker, zero fill and the 64-bit bit length, adding an extra chunk when needed.
module sha256_padder #(
   parameter int unsigned LEN_W = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   sha256_padder_if.slave bus_io
);

   typedef enum logic [1:0] {StFill, StEmit, StPad} state_e;

   state_e            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              pad_pend_q, pad_pend_d;
   logic              last_q, last_d;
   logic              pad_req_q, pad_req_d;
   logic [15:0][31:0] buf_q, buf_d;

   logic              msg_fire, chunk_fire, full_word;
   logic [LEN_W-1:0]  cnt_inc;
   logic [63:0]       len_inc, len_cur;
   logic [31:0]       last_word;
   logic [4:0]        mark_idx;

   assign msg_fire   = bus_io.msg_vld & bus_io.msg_rdy;
   assign chunk_fire = bus_io.chunk_vld & bus_io.chunk_rdy;
   assign full_word  = bus_io.msg_bytes[2];
   assign cnt_inc    = cnt_q + LEN_W'({bus_io.msg_bytes, 3'b000});
   // A full final word pushes the marker into the following word slot.
   assign mark_idx   = {1'b0, idx_q} + {4'b0000, full_word};

   always_comb begin
      len_inc = '0;
      len_cur = '0;
      len_inc[LEN_W-1:0] = cnt_inc;
      len_cur[LEN_W-1:0] = cnt_q;
   end

   always_comb begin
      unique case (bus_io.msg_bytes)
         3'd0:    last_word = 32'h8000_0000;
         3'd1:    last_word = {bus_io.msg_data[31:24], 24'h80_0000};
         3'd2:    last_word = {bus_io.msg_data[31:16], 16'h8000};
         3'd3:    last_word = {bus_io.msg_data[31:8], 8'h80};
         default: last_word = bus_io.msg_data;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StFill;
         idx_q      <= '0;
         cnt_q      <= '0;
         pad_pend_q <= 1'b0;
         last_q     <= 1'b0;
         pad_req_q  <= 1'b0;
         buf_q      <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         pad_pend_q <= pad_pend_d;
         last_q     <= last_d;
         pad_req_q  <= pad_req_d;
         buf_q      <= buf_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFill: begin
            if (msg_fire && (bus_io.msg_last || idx_q == 4'd15)) state_d = StEmit;
         end
         StEmit: begin
            if (chunk_fire) begin
               if (last_q)         state_d = StFill;
               else if (pad_req_q) state_d = StPad;
               else                state_d = StFill;
            end
         end
         StPad:   state_d = StEmit;
         default: state_d = StFill;
      endcase
   end

   // Datapath next-state
   always_comb begin
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      pad_pend_d = pad_pend_q;
      last_d     = last_q;
      pad_req_d  = pad_req_q;
      buf_d      = buf_q;
      unique case (state_q)
         StFill: begin
            if (msg_fire) begin
               cnt_d = cnt_inc;
               if (!bus_io.msg_last) begin
                  buf_d[idx_q] = bus_io.msg_data;
                  idx_d        = idx_q + 4'd1;
                  last_d       = 1'b0;
                  pad_req_d    = 1'b0;
               end else begin
                  for (int i = 0; i < 16; i++) begin
                     if (4'(i) > idx_q) buf_d[i] = '0;
                  end
                  buf_d[idx_q] = last_word;
                  idx_d        = '0;
                  if (full_word) begin
                     if (idx_q == 4'd15) pad_pend_d = 1'b1;
                     else                buf_d[idx_q + 4'd1] = 32'h8000_0000;
                  end
                  if (mark_idx <= 5'd13) begin
                     buf_d[14] = len_inc[63:32];
                     buf_d[15] = len_inc[31:0];
                     last_d    = 1'b1;
                     pad_req_d = 1'b0;
                  end else begin
                     last_d    = 1'b0;
                     pad_req_d = 1'b1;
                  end
               end
            end
         end
         StEmit: begin
            if (chunk_fire && last_q) begin
               cnt_d      = '0;
               pad_pend_d = 1'b0;
               idx_d      = '0;
            end
         end
         StPad: begin
            buf_d     = '0;
            buf_d[0]  = pad_pend_q ? 32'h8000_0000 : 32'h0;
            buf_d[14] = len_cur[63:32];
            buf_d[15] = len_cur[31:0];
            last_d    = 1'b1;
            pad_req_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      bus_io.msg_rdy    = (state_q == StFill) & rst_ni;
      bus_io.chunk_vld  = (state_q == StEmit);
      bus_io.chunk_last = (state_q == StEmit) & last_q;
      bus_io.chunk_data = buf_q;
   end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: hand-computed chunks plus a byte-level padding model.
module tb_sha256_padder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_padder_if ifc ();

   sha256_padder #(.LEN_W(64)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (ifc.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [511:0]  got_q[$];
   bit            got_last_q[$];
   logic [511:0]  exp_q[$];
   bit            exp_last_q[$];
   byte unsigned  msg[$];
   bit            rand_rdy = 1'b0;
   bit            rdy_hold = 1'b1;

   // Sink: drive chunk_rdy and log every chunk that will transfer on the next edge.
   always @(negedge clk) begin
      ifc.chunk_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_hold;
      if (rst_n && ifc.chunk_vld && ifc.chunk_rdy) begin
         got_q.push_back(ifc.chunk_data);
         got_last_q.push_back(ifc.chunk_last);
      end
   end

   function automatic void build_model();
      byte unsigned p[$];
      longint unsigned bits;
      int nch;
      logic [511:0] ch;
      exp_q.delete();
      exp_last_q.delete();
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
      nch = p.size() / 64;
      for (int c = 0; c < nch; c++) begin
         ch = '0;
         for (int w = 0; w < 16; w++)
            ch[32*w +: 32] = {p[c*64+4*w], p[c*64+4*w+1], p[c*64+4*w+2], p[c*64+4*w+3]};
         exp_q.push_back(ch);
         exp_last_q.push_back(c == nch - 1);
      end
   endfunction

   task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input bit last);
      int t = 0;
      @(negedge clk);
      ifc.msg_vld   = 1'b1;
      ifc.msg_data  = d;
      ifc.msg_bytes = nb;
      ifc.msg_last  = last;
      while (ifc.msg_rdy !== 1'b1) begin
         if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL msg_rdy_timeout: msg_rdy=%b required 1 within 500 cycles", ifc.msg_rdy);
            ifc.msg_vld = 1'b0;
            return;
         end
         @(negedge clk);
         t++;
      end
      @(posedge clk);
   endtask

   // Unused byte lanes carry 0xEE so that masking of the final word is exercised.
   task automatic send_msg(input bit gaps);
      int n, nw, nb;
      logic [31:0] d;
      n  = msg.size();
      nw = (n == 0) ? 1 : (n + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         nb = (n - 4*w >= 4) ? 4 : n - 4*w;
         d  = 32'hEEEE_EEEE;
         for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg[4*w+b];
         if (gaps) begin
            @(negedge clk);
            ifc.msg_vld = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         send_word(d, 3'(nb), w == nw - 1);
      end
      @(negedge clk);
      ifc.msg_vld = 1'b0;
   endtask

   task automatic wait_chunks(input int n);
      int t = 0;
      while (got_q.size() < n && t < 2000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_got();
      got_q.delete();
      got_last_q.delete();
   endtask

   task automatic test_reset();
      #12;
      checks += 4;
      if (ifc.msg_rdy !== 1'b0) begin
         errors++; $display("FAIL reset_msg_rdy: got %b want 0", ifc.msg_rdy);
      end
      if (ifc.chunk_vld !== 1'b0) begin
         errors++; $display("FAIL reset_chunk_vld: got %b want 0", ifc.chunk_vld);
      end
      if (ifc.chunk_last !== 1'b0) begin
         errors++; $display("FAIL reset_chunk_last: got %b want 0", ifc.chunk_last);
      end
      if (ifc.chunk_data !== 512'h0) begin
         errors++; $display("FAIL reset_chunk_data: got %h want 0", ifc.chunk_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ifc.msg_rdy !== 1'b1) begin
         errors++; $display("FAIL post_reset_msg_rdy: got %b want 1", ifc.msg_rdy);
      end
   endtask

   task automatic test_empty();
      logic [511:0] e;
      clear_got();
      msg.delete();
      send_msg(1'b0);
      wait_chunks(1);
      e = '0;
      e[31:0] = 32'h8000_0000;
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL empty_count: got %0d want 1", got_q.size());
      end else begin
         checks += 2;
         if (got_q[0] !== e) begin
            errors++; $display("FAIL empty_data: got %h want %h", got_q[0], e);
         end
         if (got_last_q[0] !== 1'b1) begin
            errors++; $display("FAIL empty_last: got %b want 1", got_last_q[0]);
         end
      end
   endtask

   task automatic test_abc();
      logic [511:0] e;
      clear_got();
      send_word(32'h6162_6300, 3'd3, 1'b1);
      #1;
      checks++;
      if (ifc.chunk_vld !== 1'b1) begin
         errors++; $display("FAIL abc_latency: chunk_vld=%b want 1 one cycle after accept", ifc.chunk_vld);
      end
      @(negedge clk);
      ifc.msg_vld = 1'b0;
      wait_chunks(1);
      e = '0;
      e[31:0]    = 32'h6162_6380;
      e[511:480] = 32'h0000_0018;
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL abc_count: got %0d want 1", got_q.size());
      end else begin
         checks += 2;
         if (got_q[0] !== e) begin
            errors++; $display("FAIL abc_data: got %h want %h", got_q[0], e);
         end
         if (got_last_q[0] !== 1'b1) begin
            errors++; $display("FAIL abc_last: got %b want 1", got_last_q[0]);
         end
      end
   endtask

   task automatic test_55_56();
      clear_got();
      msg.delete();
      for (int i = 0; i < 55; i++) msg.push_back(8'(i + 1));
      send_msg(1'b0);
      wait_chunks(1);
      checks++;
      if (got_q.size() != 1) begin
         errors++; $display("FAIL len55_count: got %0d want 1", got_q.size());
      end else begin
         checks += 3;
         if (got_q[0][13*32 +: 32] !== 32'h3536_3780) begin
            errors++; $display("FAIL len55_w13: got %h want 35363780", got_q[0][13*32 +: 32]);
         end
         if (got_q[0][15*32 +: 32] !== 32'h0000_01B8) begin
            errors++; $display("FAIL len55_w15: got %h want 000001b8", got_q[0][15*32 +: 32]);
         end
         if (got_last_q[0] !== 1'b1) begin
            errors++; $display("FAIL len55_last: got %b want 1", got_last_q[0]);
         end
      end

      clear_got();
      msg.push_back(8'h38);
      build_model();
      send_msg(1'b0);
      wait_chunks(2);
      checks++;
      if (got_q.size() != 2) begin
         errors++; $display("FAIL len56_count: got %0d want 2", got_q.size());
      end else begin
         checks += 6;
         if (got_q[0][14*32 +: 32] !== 32'h8000_0000) begin
            errors++; $display("FAIL len56_c0_w14: got %h want 80000000", got_q[0][14*32 +: 32]);
         end
         if (got_last_q[0] !== 1'b0) begin
            errors++; $display("FAIL len56_c0_last: got %b want 0", got_last_q[0]);
         end
         if (got_q[1][31:0] !== 32'h0) begin
            errors++; $display("FAIL len56_c1_w0: got %h want 00000000", got_q[1][31:0]);
         end
         if (got_q[1][15*32 +: 32] !== 32'h0000_01C0) begin
            errors++; $display("FAIL len56_c1_w15: got %h want 000001c0", got_q[1][15*32 +: 32]);
         end
         if (got_last_q[1] !== 1'b1) begin
            errors++; $display("FAIL len56_c1_last: got %b want 1", got_last_q[1]);
         end
         if (got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            errors++; $display("FAIL len56_model: got %h %h want %h %h",
                               got_q[0], got_q[1], exp_q[0], exp_q[1]);
         end
      end
   endtask

   task automatic test_64();
      logic [511:0] e;
      int t = 0;
      clear_got();
      msg.delete();
      for (int i = 0; i < 64; i++) msg.push_back(8'($urandom_range(0, 255)));
      build_model();
      rdy_hold = 1'b0;
      send_msg(1'b0);
      while (got_q.size() < 2 && t < 200) begin
         @(negedge clk);
         if (ifc.chunk_vld) begin
            checks++;
            if (ifc.msg_rdy !== 1'b0) begin
               errors++; $display("FAIL len64_msg_rdy_in_emit: got %b want 0", ifc.msg_rdy);
            end
         end
         rdy_hold = (t % 4 == 3);
         t++;
      end
      rdy_hold = 1'b1;
      wait_chunks(2);
      e = '0;
      e[31:0]    = 32'h8000_0000;
      e[511:480] = 32'h0000_0200;
      checks++;
      if (got_q.size() != 2) begin
         errors++; $display("FAIL len64_count: got %0d want 2", got_q.size());
      end else begin
         checks += 4;
         if (got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL len64_c0_data: got %h want %h", got_q[0], exp_q[0]);
         end
         if (got_q[1] !== e) begin
            errors++; $display("FAIL len64_c1_data: got %h want %h", got_q[1], e);
         end
         if (got_last_q[0] !== 1'b0) begin
            errors++; $display("FAIL len64_c0_last: got %b want 0", got_last_q[0]);
         end
         if (got_last_q[1] !== 1'b1) begin
            errors++; $display("FAIL len64_c1_last: got %b want 1", got_last_q[1]);
         end
      end
   endtask

   task automatic test_stall();
      logic [511:0] snap;
      logic         snap_last;
      int t = 0;
      clear_got();
      msg.delete();
      msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
      build_model();
      rdy_hold = 1'b0;
      send_msg(1'b0);
      while (ifc.chunk_vld !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      snap      = ifc.chunk_data;
      snap_last = ifc.chunk_last;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (ifc.chunk_vld !== 1'b1 || ifc.msg_rdy !== 1'b0 || ifc.chunk_data !== snap ||
             ifc.chunk_last !== snap_last) begin
            errors++;
            $display("FAIL stall_hold cycle %0d: vld=%b rdy=%b last=%b data=%h want vld=1 rdy=0 last=%b data=%h",
                     i, ifc.chunk_vld, ifc.msg_rdy, ifc.chunk_last, ifc.chunk_data, snap_last, snap);
         end
      end
      rdy_hold = 1'b1;
      wait_chunks(1);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0] || got_last_q[0] !== 1'b1) begin
         errors++; $display("FAIL stall_chunk: count=%0d want 1, chunk %h want %h",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 512'h0, exp_q[0]);
      end
   endtask

   task automatic test_random();
      clear_got();
      msg.delete();
      for (int i = 0; i < 200; i++) msg.push_back(8'($urandom_range(0, 255)));
      build_model();
      rand_rdy = 1'b1;
      send_msg(1'b1);
      wait_chunks(exp_q.size());
      rand_rdy = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
      end else begin
         for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (got_q[c] !== exp_q[c] || got_last_q[c] !== exp_last_q[c]) begin
               errors++; $display("FAIL rand_chunk%0d: got %h last %b want %h last %b",
                                  c, got_q[c], got_last_q[c], exp_q[c], exp_last_q[c]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [511:0] e;
      clear_got();
      for (int w = 0; w < 7; w++) send_word(32'h1111_1111 * (w + 1), 3'd4, 1'b0);
      @(negedge clk);
      ifc.msg_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      checks += 2;
      if (ifc.msg_rdy !== 1'b0) begin
         errors++; $display("FAIL midrst_msg_rdy: got %b want 0", ifc.msg_rdy);
      end
      if (ifc.chunk_vld !== 1'b0) begin
         errors++; $display("FAIL midrst_chunk_vld: got %b want 0", ifc.chunk_vld);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_word(32'h6162_6300, 3'd3, 1'b1);
      @(negedge clk);
      ifc.msg_vld = 1'b0;
      wait_chunks(1);
      repeat (5) @(negedge clk);
      e = '0;
      e[31:0]    = 32'h6162_6380;
      e[511:480] = 32'h0000_0018;
      checks++;
      if (got_q.size() != 1 || got_q[0] !== e || got_last_q[0] !== 1'b1) begin
         errors++; $display("FAIL midrst_abc: count=%0d want 1, chunk %h want %h",
                            got_q.size(), (got_q.size() > 0) ? got_q[0] : 512'h0, e);
      end
   endtask

   initial begin
      ifc.msg_vld   = 1'b0;
      ifc.msg_data  = '0;
      ifc.msg_last  = 1'b0;
      ifc.msg_bytes = '0;
      test_reset();
      test_empty();
      test_abc();
      test_55_56();
      test_64();
      test_stall();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
